// File: rtl/uart_word_loader.sv
// uart_word_loader: turns a UART byte stream into addressed 32-bit memory writes.
// Packet: 4-byte little-endian word count N, then N little-endian 32-bit words.
// Writes leave on a valid/ready port at addresses 0..N-1.
// Optional feature: define UART_LOADER_CHECKSUM_EN to require one trailing
// checksum byte equal to the XOR of all data bytes.
module uart_word_loader #(
  parameter int ADDR_W         = 12,
  parameter int TIMEOUT_CYCLES = 86800,
  parameter int TIMER_W        = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  input  logic              in_err,
  input  logic              restart,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

`ifdef UART_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_HDR, S_DATA, S_CSUM, S_DONE, S_ERROR} state_t;
  localparam state_t S_AFTER_DATA = S_CSUM;
`else
  typedef enum logic [2:0] {S_HDR, S_DATA, S_DONE, S_ERROR} state_t;
  localparam state_t S_AFTER_DATA = S_DONE;
`endif

  localparam logic [31:0]        MAX_N        = 32'd1 << ADDR_W;
  localparam logic [ADDR_W:0]    PTR_ONE      = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_ONE    = {{(TIMER_W-1){1'b0}}, 1'b1};
  localparam logic [1:0]         ERR_OVERFLOW = 2'd1;
  localparam logic [1:0]         ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0]         ERR_FRAME    = 2'd3;

  state_t             state, state_next;
  logic [1:0]         byte_idx;
  logic [31:0]        acc, acc_next;
  logic [ADDR_W:0]    word_cnt, wr_ptr;
  logic [TIMER_W-1:0] timer;
  logic               active, accept, last_byte, timeout;
  logic               load_word, err_set;
  logic [1:0]         err_code_next;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]         csum;
`endif

  // Bytes are only consumed while a packet can still make progress.
  assign active    = (state != S_DONE) && (state != S_ERROR);
  assign accept    = in_valid && active && !restart;
  assign last_byte = (byte_idx == 2'd3);
  assign acc_next  = {in_byte, acc[31:8]};
`ifdef UART_LOADER_CHECKSUM_EN
  assign busy      = (state == S_DATA) || (state == S_CSUM) || (byte_idx != 2'd0);
`else
  assign busy      = (state == S_DATA) || (byte_idx != 2'd0);
`endif
  assign timeout   = busy && !in_valid && (timer == '0);
  assign done      = (state == S_DONE) && !out_valid;
  assign error     = (state == S_ERROR);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!reset_n) state <= S_HDR;
    else          state <= state_next;
  end

  // Next-state decode; errors are applied lowest priority first so that
  // framing/size overrides overflow, which overrides timeout.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_next    = state;
    load_word     = 1'b0;
    err_set       = 1'b0;
    err_code_next = 2'd0;
    if (timeout) begin
      err_set       = 1'b1;
      err_code_next = ERR_TIMEOUT;
    end
    case (state)
      S_HDR: if (accept && last_byte) begin
        if (acc_next > MAX_N) begin
          err_set       = 1'b1;
          err_code_next = ERR_FRAME;
        end else if (acc_next == 32'd0) begin
          state_next = S_AFTER_DATA;
        end else begin
          state_next = S_DATA;
        end
      end
      S_DATA: if (accept && last_byte) begin
        if (out_valid && !out_ready) begin
          err_set       = 1'b1;
          err_code_next = ERR_OVERFLOW;
        end else begin
          load_word = 1'b1;
          if (wr_ptr + PTR_ONE == word_cnt) state_next = S_AFTER_DATA;
        end
      end
`ifdef UART_LOADER_CHECKSUM_EN
      S_CSUM: if (accept) begin
        if (in_byte == csum) begin
          state_next = S_DONE;
        end else begin
          err_set       = 1'b1;
          err_code_next = ERR_FRAME;
        end
      end
`endif
      default: ;
    endcase
    if (active && in_err) begin
      err_set       = 1'b1;
      err_code_next = ERR_FRAME;
    end
    if (err_set) begin
      state_next = S_ERROR;
      load_word  = 1'b0;
    end
    if (restart) begin
      state_next = S_HDR;
      load_word  = 1'b0;
      err_set    = 1'b0;
    end
  end

  // Byte assembly, write pointer, output port, error code and idle timer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_idx  <= 2'd0;
      acc       <= 32'd0;
      word_cnt  <= '0;
      wr_ptr    <= '0;
      timer     <= TIMER_RELOAD;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= 32'd0;
      err_code  <= 2'd0;
    end else if (restart) begin
      byte_idx  <= 2'd0;
      acc       <= 32'd0;
      word_cnt  <= '0;
      wr_ptr    <= '0;
      timer     <= TIMER_RELOAD;
      out_valid <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      if (accept) begin
        acc <= acc_next;
        // The checksum byte is a lone byte, so it never opens a word.
        byte_idx <= (state == S_HDR || state == S_DATA) ? byte_idx + 2'd1 : 2'd0;
      end
      if (state == S_HDR && accept && last_byte) word_cnt <= acc_next[ADDR_W:0];
      if (load_word) begin
        out_valid <= 1'b1;
        out_addr  <= wr_ptr[ADDR_W-1:0];
        out_data  <= acc_next;
        wr_ptr    <= wr_ptr + PTR_ONE;
      end else if (state_next == S_ERROR || out_ready) begin
        // Address/data stay put so an aborted word remains observable.
        out_valid <= 1'b0;
      end
      if (err_set) begin
        byte_idx <= 2'd0;
        err_code <= err_code_next;
      end
      if (in_valid || !busy)  timer <= TIMER_RELOAD;
      else if (timer != '0)   timer <= timer - TIMER_ONE;
    end
  end

`ifdef UART_LOADER_CHECKSUM_EN
  // Running XOR of data bytes; header bytes never contribute.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           csum <= 8'd0;
    else if (restart || state == S_HDR)     csum <= 8'd0;
    else if (state == S_DATA && accept)     csum <= csum ^ in_byte;
  end
`endif

endmodule

// File: tb/tb_uart_word_loader.sv
// Self-checking bench for uart_word_loader. A scoreboard of expected writes is
// filled from the packets the bench sends; one negedge process checks every
// accepted write and the hold rule. Directed cases cover reset, overflow,
// timeout, size limits, restart, framing error and (when built with
// UART_LOADER_CHECKSUM_EN) the checksum byte; a random phase follows.
module tb_uart_word_loader;
  localparam int ADDR_W  = 12;
  localparam int TIMEOUT = 300;
  localparam int TIMER_W = 9;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [7:0]        in_byte;
  logic              in_valid, in_err, restart, out_ready;
  logic              out_valid, busy, done, error;
  logic [ADDR_W-1:0] out_addr;
  logic [31:0]       out_data;
  logic [1:0]        err_code;

  always #5 clk = ~clk;

  uart_word_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT), .TIMER_W(TIMER_W)) dut (
    .clk(clk), .reset_n(reset_n), .in_byte(in_byte), .in_valid(in_valid),
    .in_err(in_err), .restart(restart), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .busy(busy), .done(done),
    .error(error), .err_code(err_code)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t               exp_q[$];
  int                checks = 0;
  int                errors = 0;
  logic              ready_rand = 1'b0;
  logic [7:0]        csum_model = 8'd0;
  logic              prev_valid = 1'b0;
  logic              prev_ready = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [31:0]       prev_data = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // One clock; inputs change 1ns after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ready_rand) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_byte  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_header(input logic [31:0] n);
    csum_model = 8'd0;
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
  endtask

  // flow=1 behaves like a polite sender: the last byte of a word waits until
  // the previous word has left the port.
  task automatic send_word(input logic [31:0] w, input bit flow, input int gap_max);
    for (int i = 0; i < 4; i++) begin
      if (i == 3 && flow) begin
        for (int k = 0; k < 100 && out_valid; k++) tick();
        if (out_valid) check("flow_wait_bound", 32'(out_valid), 32'd0);
      end
      send_byte(w[8*i +: 8]);
      csum_model = csum_model ^ w[8*i +: 8];
      idle($urandom_range(0, gap_max));
    end
  endtask

  task automatic send_csum();
`ifdef UART_LOADER_CHECKSUM_EN
    send_byte(csum_model);
`endif
  endtask

  task automatic wait_done();
    for (int k = 0; k < 200 && !done; k++) tick();
    check("done", 32'(done), 32'd1);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    exp_q.delete();
  endtask

  // Scoreboard: every accepted write must be the next expected one, and a
  // stalled word must not change.
  always @(negedge clk) begin
    wr_t e;
    if (reset_n) begin
      if (out_valid && prev_valid && !prev_ready) begin
        check("hold_addr", 32'(out_addr), 32'(prev_addr));
        check("hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h, expected none", out_addr, out_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(out_addr), 32'(e.addr));
          check("wr_data", out_data, e.data);
        end
      end
    end
    prev_valid = reset_n && out_valid;
    prev_ready = out_ready;
    prev_addr  = out_addr;
    prev_data  = out_data;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] w0, w1;
    int          n;
    in_byte = 8'd0; in_valid = 1'b0; in_err = 1'b0; restart = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_error",     32'(error),     32'd0);
    check("rst_err_code",  32'(err_code),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    reset_n = 1'b1;
    tick();

    // Two-word packet, sink always ready.
    out_ready = 1'b1;
    expect_wr(12'd0, 32'h44332211);
    expect_wr(12'd1, 32'h88776655);
    send_header(32'd2);
    send_word(32'h44332211, 1'b1, 0);
    send_word(32'h88776655, 1'b1, 0);
    send_csum();
    wait_done();
    check("basic_error", 32'(error), 32'd0);
    check("basic_all_written", 32'(exp_q.size()), 32'd0);
    check("basic_busy", 32'(busy), 32'd0);
    do_restart();
    check("restart_done", 32'(done), 32'd0);

    // Sink stalled: the second word overflows, the first stays on the port.
    out_ready = 1'b0;
    expect_wr(12'd0, 32'h44332211);
    send_header(32'd2);
    send_word(32'h44332211, 1'b0, 0);
    check("stall_valid", 32'(out_valid), 32'd1);
    send_word(32'h88776655, 1'b0, 0);
    check("ovf_error", 32'(error), 32'd1);
    check("ovf_code", 32'(err_code), 32'd1);
    check("ovf_dropped", 32'(out_valid), 32'd0);
    check("ovf_addr_held", 32'(out_addr), 32'd0);
    check("ovf_data_held", out_data, 32'h44332211);
    idle(10);
    out_ready = 1'b1;
    idle(2);
    check("ovf_error_sticky", 32'(error), 32'd1);
    do_restart();
    check("restart_error", 32'(error), 32'd0);
    check("restart_code", 32'(err_code), 32'd0);

    // A word completing in the same cycle the sink accepts replaces it cleanly.
    out_ready = 1'b0;
    w0 = 32'hA5A5_0001; w1 = 32'h5A5A_0002;
    expect_wr(12'd0, w0);
    expect_wr(12'd1, w1);
    send_header(32'd2);
    send_word(w0, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      send_byte(w1[8*i +: 8]);
      csum_model = csum_model ^ w1[8*i +: 8];
    end
    out_ready = 1'b1;
    send_byte(w1[31:24]);
    csum_model = csum_model ^ w1[31:24];
    check("replace_no_error", 32'(error), 32'd0);
    send_csum();
    wait_done();
    check("replace_all_written", 32'(exp_q.size()), 32'd0);
    do_restart();

    // Timeout: header plus two bytes, then silence.
    send_header(32'd1);
    send_byte(8'hA1);
    send_byte(8'hA2);
    idle(TIMEOUT - 3);
    check("to_not_early", 32'(error), 32'd0);
    check("to_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 10 && !error; k++) tick();
    check("to_error", 32'(error), 32'd1);
    check("to_code", 32'(err_code), 32'd2);
    check("to_no_valid", 32'(out_valid), 32'd0);
    do_restart();

    // Size limits: 8192 and 4097 rejected, 4096 accepted.
    send_header(32'h0000_2000);
    check("size_8192_error", 32'(error), 32'd1);
    check("size_8192_code", 32'(err_code), 32'd3);
    do_restart();
    send_header(32'd4097);
    check("size_4097_code", 32'(err_code), 32'd3);
    do_restart();
    send_header(32'd4096);
    check("size_4096_error", 32'(error), 32'd0);
    check("size_4096_busy", 32'(busy), 32'd1);
    do_restart();

    // Empty packet.
    send_header(32'd0);
    send_csum();
    wait_done();
    do_restart();

    // Framing error from the receiver.
    send_header(32'd1);
    in_err = 1'b1;
    tick();
    in_err = 1'b0;
    check("frame_error", 32'(error), 32'd1);
    check("frame_code", 32'(err_code), 32'd3);
    do_restart();

    // restart beats a simultaneous byte.
    in_byte = 8'h55; in_valid = 1'b1; restart = 1'b1;
    tick();
    in_valid = 1'b0; restart = 1'b0;
    check("restart_wins", 32'(busy), 32'd0);

    // restart mid-word, then a fresh one-word packet.
    send_header(32'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    do_restart();
    check("restart_mid_busy", 32'(busy), 32'd0);
    expect_wr(12'd0, 32'hDEADBEEF);
    send_header(32'd1);
    send_word(32'hDEADBEEF, 1'b1, 1);
    send_csum();
    wait_done();
    check("restart_pkt_written", 32'(exp_q.size()), 32'd0);
    do_restart();

    // Reset mid-packet discards the partial word.
    send_header(32'd1);
    send_byte(8'h12);
    reset_n = 1'b0;
    #1;
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_valid", 32'(out_valid), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    expect_wr(12'd0, 32'hCAFEF00D);
    send_header(32'd1);
    send_word(32'hCAFEF00D, 1'b1, 0);
    send_csum();
    wait_done();
    check("after_reset_written", 32'(exp_q.size()), 32'd0);
    do_restart();

`ifdef UART_LOADER_CHECKSUM_EN
    // Checksum byte: XOR of 04 03 02 01 is 04.
    expect_wr(12'd0, 32'h01020304);
    send_header(32'd1);
    send_word(32'h01020304, 1'b1, 0);
    send_byte(8'h04);
    wait_done();
    check("csum_ok_error", 32'(error), 32'd0);
    do_restart();
    expect_wr(12'd0, 32'h01020304);
    send_header(32'd1);
    send_word(32'h01020304, 1'b1, 0);
    send_byte(8'h05);
    idle(2);
    check("csum_bad_error", 32'(error), 32'd1);
    check("csum_bad_code", 32'(err_code), 32'd3);
    do_restart();
`endif

    // Random packets with a randomly stalling sink.
    ready_rand = 1'b1;
    for (int p = 0; p < 8; p++) begin
      n = $urandom_range(1, 8);
      send_header(32'(n));
      for (int i = 0; i < n; i++) begin
        w0 = $urandom;
        expect_wr(ADDR_W'(i), w0);
        send_word(w0, 1'b1, 3);
      end
      send_csum();
      wait_done();
      check("rand_error", 32'(error), 32'd0);
      check("rand_all_written", 32'(exp_q.size()), 32'd0);
      do_restart();
    end
    ready_rand = 1'b0;
    out_ready  = 1'b1;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
